// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/seq_alu_shift_add_mul.sv
// Iterative shift-add multiplier: load latches operands, each step consumes one multiplier bit.
// prod_o shows the accumulator value after the current step so the caller can capture the
// final product on the same edge that performs the last step.
module shift_add_mul #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic                 clk_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic                 done_o
);

  localparam int CW = $clog2(MUL_STEPS + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // Conditional add of the shifted multiplicand for the current multiplier bit.
  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  assign prod_o = acc_d;
  assign done_o = step_i && (cnt_q == CW'(MUL_STEPS - 1));

  // Operand load or one shift-add iteration.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execution unit: single-cycle logic/arithmetic, bit-serial shifts and an
// iterative MUL. Produces the writeback value, destination tag pulse and status flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] ABUS,
  input  logic [WIDTH-1:0] BBUS,
  input  logic [2:0]       OP,
  input  logic             START,
  input  logic [2:0]       DSEL_IN,
  output logic [WIDTH-1:0] RIN,
  output logic [2:0]       DSEL_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       FLAGS
);

  state_e             state_q;
  logic [2:0]         op_q;
  logic [2:0]         dsel_q;
  logic [WIDTH-1:0]   sh_q;
  logic [3:0]         cnt_q;
  logic [WIDTH-1:0]   rin_q;
  logic [2:0]         dsel_out_q;
  logic               done_q;
  logic [3:0]         flags_q;

  logic [WIDTH:0]     sc_ext;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_out;
  logic               accept;
  logic               is_shift;
  logic [2*WIDTH-1:0] prod;
  logic               mul_last;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = (r == '0);
    f[FLG_N] = r[WIDTH-1];
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

  assign accept   = START && (state_q == ST_IDLE);
  assign is_shift = (OP == OP_SHL) || (OP == OP_SHR);

  // Single-cycle result and carry/overflow; zero-amount shifts pass A through.
  always_comb begin
    sc_ext = '0;
    sc_res = ABUS;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        sc_ext = {1'b0, ABUS} + {1'b0, BBUS};
        sc_res = sc_ext[WIDTH-1:0];
        sc_c   = sc_ext[WIDTH];
        sc_v   = (ABUS[WIDTH-1] == BBUS[WIDTH-1]) && (sc_res[WIDTH-1] != ABUS[WIDTH-1]);
      end
      OP_SUB: begin
        sc_ext = {1'b0, ABUS} - {1'b0, BBUS};
        sc_res = sc_ext[WIDTH-1:0];
        sc_c   = sc_ext[WIDTH];
        sc_v   = (ABUS[WIDTH-1] != BBUS[WIDTH-1]) && (sc_res[WIDTH-1] != ABUS[WIDTH-1]);
      end
      OP_AND:  sc_res = ABUS & BBUS;
      OP_OR:   sc_res = ABUS | BBUS;
      OP_XOR:  sc_res = ABUS ^ BBUS;
      default: sc_res = ABUS;
    endcase
  end

  // One-bit shift step; sh_out is the bit leaving the register on this step.
  always_comb begin
    if (op_q == OP_SHL) begin
      sh_nxt = sh_q << 1;
      sh_out = sh_q[WIDTH-1];
    end else begin
      sh_nxt = sh_q >> 1;
      sh_out = sh_q[0];
    end
  end

  shift_add_mul #(
    .WIDTH    (WIDTH),
    .MUL_STEPS(MUL_STEPS)
  ) u_mul (
    .clk_i (CLK),
    .load_i(accept && (OP == OP_MUL)),
    .step_i(state_q == ST_MUL),
    .a_i   (ABUS),
    .b_i   (BBUS),
    .prod_o(prod),
    .done_o(mul_last)
  );

  // Control FSM with registered writeback, tag pulse and flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      rin_q      <= '0;
      dsel_out_q <= '0;
      done_q     <= 1'b0;
      flags_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      dsel_out_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            op_q   <= OP;
            dsel_q <= DSEL_IN;
            if (OP == OP_MUL) begin
              state_q <= ST_MUL;
            end else if (is_shift && (BBUS[3:0] != 4'd0)) begin
              state_q <= ST_SHIFT;
              sh_q    <= ABUS;
              cnt_q   <= BBUS[3:0];
            end else begin
              rin_q      <= sc_res;
              flags_q    <= mk_flags(sc_res, sc_c, sc_v);
              done_q     <= 1'b1;
              dsel_out_q <= DSEL_IN;
            end
          end
        end
        ST_SHIFT: begin
          sh_q  <= sh_nxt;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= ST_IDLE;
            rin_q      <= sh_nxt;
            flags_q    <= mk_flags(sh_nxt, sh_out, 1'b0);
            done_q     <= 1'b1;
            dsel_out_q <= dsel_q;
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            state_q    <= ST_IDLE;
            rin_q      <= prod[WIDTH-1:0];
            flags_q    <= mk_flags(prod[WIDTH-1:0], |prod[2*WIDTH-1:WIDTH], 1'b0);
            done_q     <= 1'b1;
            dsel_out_q <= dsel_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign RIN      = rin_q;
  assign DSEL_OUT = dsel_out_q;
  assign DONE     = done_q;
  assign FLAGS    = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with an in-order scoreboard of expected completions.
module tb_seq_alu;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ABUS = '0;
  logic [15:0] BBUS = '0;
  logic [2:0]  OP = '0;
  logic        START = 1'b0;
  logic [2:0]  DSEL_IN = '0;
  logic [15:0] RIN;
  logic [2:0]  DSEL_OUT;
  logic        BUSY;
  logic        DONE;
  logic [3:0]  FLAGS;

  typedef struct {
    logic [15:0] rin;
    logic [2:0]  dsel;
    logic [3:0]  fl;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc_n = 0;

  seq_alu dut (
    .CLK(CLK), .RST(RST), .ABUS(ABUS), .BBUS(BBUS), .OP(OP), .START(START),
    .DSEL_IN(DSEL_IN), .RIN(RIN), .DSEL_OUT(DSEL_OUT), .BUSY(BUSY), .DONE(DONE),
    .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: result, {Z,N,C,V} and latency in cycles.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [2:0] d);
    exp_t e;
    logic [31:0] w;
    logic [15:0] r;
    logic c, v;
    int k;
    c = 1'b0; v = 1'b0; k = int'(b[3:0]); e.cyc = 1; w = '0;
    case (op)
      ADD: begin
        w = {16'h0, a} + {16'h0, b}; r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      SUB: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      SHL: begin
        w = {16'h0, a} << k; r = w[15:0]; c = (k != 0) ? w[16] : 1'b0;
        e.cyc = (k == 0) ? 1 : k + 1;
      end
      SHR: begin
        r = a >> k; c = (k != 0) ? a[k-1] : 1'b0;
        e.cyc = (k == 0) ? 1 : k + 1;
      end
      default: begin
        w = {16'h0, a} * {16'h0, b}; r = w[15:0]; c = (w[31:16] != 16'h0);
        e.cyc = 17;
      end
    endcase
    e.rin  = r;
    e.dsel = d;
    e.fl   = {(r == 16'h0), r[15], c, v};
    return e;
  endfunction

  // Present a request in the current cycle; push an expectation only if it should be accepted.
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d, input bit accepted);
    exp_t e;
    OP = op; ABUS = a; BBUS = b; DSEL_IN = d; START = 1'b1;
    if (accepted) begin
      e = model(op, a, b, d);
      e.cyc = e.cyc + cyc_n;
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABUS = $urandom; BBUS = $urandom;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    drive(op, a, b, d, 1'b1);
    step();
  endtask

  // Leaves the caller at the negedge of the DONE cycle.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < budget);
    chk(tag, DONE, 1'b1);
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && DONE) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        chk("sb_rin", RIN, e.rin);
        chk("sb_dsel", DSEL_OUT, e.dsel);
        chk("sb_flags", FLAGS, e.fl);
        chk("sb_latency", cyc_n, e.cyc);
      end
    end
  end

  initial begin
    int pulses;
    // Reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rin", RIN, 16'h0);
    chk("rst_ctl", {DSEL_OUT, BUSY, DONE}, 5'b0);
    chk("rst_flags", FLAGS, 4'h0);
    @(posedge CLK); #1; RST = 1'b0;

    // ADD with signed overflow
    issue(ADD, 16'h7FFF, 16'h0001, 3'd3);
    @(negedge CLK);
    chk("add_done", DONE, 1'b1);
    chk("add_rin", RIN, 16'h8000);
    chk("add_dsel", DSEL_OUT, 3'd3);
    chk("add_flags", FLAGS, 4'b0101);
    @(negedge CLK);
    chk("add_dsel_clear", {DSEL_OUT, DONE}, 4'b0);
    chk("add_rin_hold", RIN, 16'h8000);

    // SUB: zero result, then borrow
    @(posedge CLK); #1;
    issue(SUB, 16'h0005, 16'h0005, 3'd1);
    @(negedge CLK);
    chk("sub0_rin", RIN, 16'h0000);
    chk("sub0_flags", FLAGS, 4'b1000);
    @(posedge CLK); #1;
    issue(SUB, 16'h0003, 16'h0005, 3'd0);
    @(negedge CLK);
    chk("sub1_rin", RIN, 16'hFFFE);
    chk("sub1_flags", FLAGS, 4'b0110);
    chk("dsel0_done", {DONE, DSEL_OUT}, 4'b1000);

    // MUL with an ignored START mid-flight and a back-to-back START in the DONE cycle
    @(posedge CLK); #1;
    issue(MUL, 16'h0123, 16'h0045, 3'd5);
    pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      if (!BUSY || DONE) pulses++;
      if (c == 8) drive(ADD, 16'h1111, 16'h2222, 3'd7, 1'b0);
      step();
    end
    chk("mul_busy_window", pulses, 0);
    drive(XOR_, 16'hA5A5, 16'h0FF0, 3'd2, 1'b1);
    @(negedge CLK);
    chk("mul_done17", {BUSY, DONE}, 2'b01);
    chk("mul_rin", RIN, 16'h4E6F);
    chk("mul_dsel", DSEL_OUT, 3'd5);
    chk("mul_c", FLAGS[1], 1'b0);
    step();
    @(negedge CLK);
    chk("mul_b2b_done", {BUSY, DONE}, 2'b01);
    chk("mul_b2b_rin", RIN, 16'hAA55);

    // MUL with overflow into the upper half
    @(posedge CLK); #1;
    issue(MUL, 16'h1000, 16'h0010, 3'd4);
    wait_done("mul2_timeout", 25);
    chk("mul2_rin", RIN, 16'h0000);
    chk("mul2_zc", {FLAGS[3], FLAGS[1]}, 2'b11);

    // Shifts: SHL by 1, SHR by 4, SHL by 0
    @(posedge CLK); #1;
    issue(SHL, 16'h8001, 16'h0001, 3'd6);
    @(negedge CLK);
    chk("shl_busy1", {BUSY, DONE}, 2'b10);
    @(negedge CLK);
    chk("shl_done2", {BUSY, DONE}, 2'b01);
    chk("shl_rin", RIN, 16'h0002);
    chk("shl_c", FLAGS[1], 1'b1);
    @(posedge CLK); #1;
    issue(SHR, 16'h00F0, 16'h0004, 3'd1);
    wait_done("shr_timeout", 10);
    chk("shr_rin", RIN, 16'h000F);
    chk("shr_c", FLAGS[1], 1'b0);
    @(posedge CLK); #1;
    issue(SHL, 16'h9234, 16'h0000, 3'd2);
    @(negedge CLK);
    chk("shl0_done1", {BUSY, DONE}, 2'b01);
    chk("shl0_flags", FLAGS, 4'b0100);

    // Back-to-back XOR/AND/OR every cycle
    @(posedge CLK); #1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive((i % 2) ? XOR_ : ((i == 2) ? OR_ : AND_), 16'h1234 * (i + 1), 16'hF0F0 >> i,
            3'(i + 1), 1'b1);
      @(negedge CLK);
      if (i > 0 && (!DONE || BUSY)) pulses++;
      step();
    end
    @(negedge CLK);
    if (!DONE || BUSY) pulses++;
    chk("b2b_stream", pulses, 0);

    // Reset in the middle of a MUL
    @(posedge CLK); #1;
    issue(ADD, 16'h7FFF, 16'h0001, 3'd3);
    issue(MUL, 16'h00FF, 16'h00FF, 3'd6);
    repeat (6) step();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    q.delete();
    @(negedge CLK);
    chk("rmid_rin", RIN, 16'h0);
    chk("rmid_flags", FLAGS, 4'h0);
    chk("rmid_ctl", {DSEL_OUT, BUSY, DONE}, 5'b0);
    pulses = 0;
    repeat (15) begin
      @(negedge CLK);
      if (DONE || BUSY || DSEL_OUT != 3'd0) pulses++;
    end
    chk("rmid_quiet", pulses, 0);
    @(posedge CLK); #1;
    issue(ADD, 16'h1234, 16'h4321, 3'd7);
    @(negedge CLK);
    chk("rmid_add_rin", RIN, 16'h5555);
    chk("rmid_add_dsel", DSEL_OUT, 3'd7);

    repeat (3) @(negedge CLK);
    chk("sb_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Multi-cycle execution unit sitting directly downstream of the register file in the uasm datapath. It consumes the A and B bus values and produces the writeback value (RIN) plus the destination select that is fed back to the register file's write port. Single-cycle logic/arithmetic ops complete in one cycle. Shifts run one bit per cycle, and MUL is an iterative 16-step shift-add. A registered status-flag word is updated on every completion.

Parameters:
WIDTH, 16, datapath width of operands and result
MUL_STEPS, 16, shift-add iterations for MUL; must equal WIDTH

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
ABUS  input  WIDTH  operand A, sampled only when START is accepted
BBUS  input  WIDTH  operand B; B[3:0] is the shift amount for SHL/SHR
OP  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
START  input  1  request; accepted when BUSY=0
DSEL_IN  input  3  destination register tag, latched with operands
RIN  output  WIDTH  result; holds last result between operations
DSEL_OUT  output  3  destination tag, non-zero only in the DONE cycle
BUSY  output  1  multi-cycle operation in progress
DONE  output  1  one-cycle completion pulse
FLAGS  output  4  {Z,N,C,V}, registered

Behaviour:
- Reset (RST=1 at an edge): RIN=0, DSEL_OUT=0, BUSY=0, DONE=0, FLAGS=0, state=IDLE. Reset wins over START and aborts any operation in flight; no DONE is produced for an aborted op.
- States: IDLE, SHIFT, MUL.
  - IDLE + START with a single-cycle op (ADD/SUB/AND/OR/XOR, or a shift with amount 0) -> stay IDLE; result registered.
  - IDLE + START with SHL/SHR and amount k>=1 -> SHIFT.
  - IDLE + START with MUL -> MUL.
  - SHIFT/MUL -> IDLE on the edge that performs the final step.
- Timing: START is high in cycle 0 and sampled at the end of cycle 0. Operands, OP and DSEL_IN are latched at that edge; later bus changes are ignored.
- Latency:
  - Single-cycle ops: DONE in cycle 1.
  - Shift by k>=1: DONE in cycle k+1.
  - MUL: DONE in cycle 17.
- BUSY: high in cycles 1 through DONE-1 and low in the DONE cycle, so a new START is accepted in the DONE cycle (back-to-back). START while BUSY=1 is ignored with no side effects. Single-cycle ops never raise BUSY, giving throughput of 1 op/cycle.
- DONE cycle: RIN=result, DSEL_OUT=latched DSEL_IN, FLAGS updated. In all other cycles DSEL_OUT=0, so the register file never writes spuriously. DSEL_IN=0 still completes and updates FLAGS.
- Arithmetic is modulo 2^WIDTH.
- Z = (result==0); N = result[15].
- C:
  - ADD: carry out.
  - SUB: borrow, i.e. A<B unsigned.
  - SHL/SHR: last bit shifted out, 0 if k=0.
  - MUL: 1 if the upper 16 bits of the 32-bit product are non-zero.
  - Logic ops: 0.
- V: signed overflow for ADD/SUB; 0 otherwise.
- FLAGS and RIN hold their values between DONE pulses.
- MUL: a 32-bit accumulator. On each step, if multiplier LSB=1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right. After step 16, RIN = low half of the accumulator.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (OP_ADD..OP_MUL)
  - state encoding (ST_IDLE, ST_SHIFT, ST_MUL)
  - flag bit indices (FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0)
- One sub-module is natural: shift_add_mul (load/step/done interface, 32-bit product out), instantiated by seq_alu.
- Single-cycle ops and flag generation stay in the top module.

Test Plan:
- ADD A=0x7FFF B=0x0001 DSEL_IN=3 -> cycle 1: DONE=1, RIN=0x8000, DSEL_OUT=3, FLAGS Z0 N1 C0 V1; cycle 2: DSEL_OUT=0.
- SUB A=0x0005 B=0x0005 -> RIN=0x0000, Z1 N0 C0 V0. Then SUB A=0x0003 B=0x0005 -> RIN=0xFFFE, N1 C1.
- MUL A=0x0123 B=0x0045 DSEL_IN=5 -> BUSY high cycles 1-16; DONE only in cycle 17 with RIN=0x4E6F, DSEL_OUT=5, C0. A START issued in cycle 8 is ignored.
- MUL A=0x1000 B=0x0010 -> RIN=0x0000, Z1 C1. SHL A=0x8001 B=0x0001 -> DONE cycle 2, RIN=0x0002, C1. SHR A=0x00F0 B=0x0004 -> DONE cycle 5, RIN=0x000F, C0.
- Back-to-back: XOR every cycle for 4 cycles -> DONE high 4 consecutive cycles, BUSY never high, each RIN correct. A START in a MUL's DONE cycle is accepted.
- Reset mid-MUL: RST=1 at cycle 8 edge -> from cycle 9: BUSY=0, DONE never pulses, DSEL_OUT=0, RIN=0, FLAGS=0; a new ADD then completes normally.
